// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the five-stage pipeline: load-use, branch-operand
// and mult/div-busy interlocks, plus a saturating stall-cycle counter.
module stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic        tuse0_id,
    input  logic        id_is_md,
    input  logic [4:0]  wa_ex,
    input  logic        ex_is_load,
    input  logic [4:0]  wa_mem,
    input  logic        mem_is_load,
    input  logic        ex_md_start,
    input  logic        ex_md_is_div,
    output logic        if_id_stall,
    output logic        pc_stall,
    output logic        id_ex_flush,
    output logic        md_busy,
    output logic [3:0]  md_cnt,
    output logic [31:0] stall_count
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SC_W  = 32;

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [SC_W-1:0]  stall_count_q, stall_count_d;

    logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
    logic src_ex_hit, src_mem_hit;
    logic load_use_haz, tuse0_haz, md_haz;
    logic md_busy_c, stall_c;

    // Source/destination matching; $0 never matches because the source must be nonzero
    always_comb begin
        rs_ex_hit    = use_rs_id && (rs_id != 5'd0) && (rs_id == wa_ex);
        rt_ex_hit    = use_rt_id && (rt_id != 5'd0) && (rt_id == wa_ex);
        rs_mem_hit   = use_rs_id && (rs_id != 5'd0) && (rs_id == wa_mem);
        rt_mem_hit   = use_rt_id && (rt_id != 5'd0) && (rt_id == wa_mem);
        src_ex_hit   = rs_ex_hit || rt_ex_hit;
        src_mem_hit  = rs_mem_hit || rt_mem_hit;

        load_use_haz = src_ex_hit && ex_is_load;
        tuse0_haz    = tuse0_id && (src_ex_hit || (src_mem_hit && mem_is_load));
        md_busy_c    = (md_cnt_q != '0) || ex_md_start;
        md_haz       = id_is_md && md_busy_c;

        // Stall outputs are forced low while reset is held
        stall_c      = !reset && (load_use_haz || tuse0_haz || md_haz);
    end

    // Next-state for the mult/div busy counter and the saturating stall counter
    always_comb begin
        md_cnt_d      = md_cnt_q;
        stall_count_d = stall_count_q;

        if (ex_md_start) begin
            md_cnt_d = ex_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end

        if (stall_c && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt_q      <= '0;
            stall_count_q <= '0;
        end else begin
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign if_id_stall = stall_c;
    assign pc_stall    = stall_c;
    assign id_ex_flush = stall_c;
    assign md_busy     = !reset && md_busy_c;
    assign md_cnt      = md_cnt_q;
    assign stall_count = stall_count_q;

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

- Hazard and stall controller for the five-stage pipeline. It is the driving end of the IF/ID register's write-enable handshake.
- Compares the ID-stage instruction's source registers against writers in EX and MEM, and tracks the multi-cycle mult/div unit with a busy down-counter.
- Generates the hold signals for PC and IF/ID plus the bubble insert for ID/EX.
- Keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu (after the start cycle)
- DIV_CYCLES, 10, busy cycles loaded for div/divu (after the start cycle)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rs_id, rt_id  in  5 each  ID source register numbers
- use_rs_id, use_rt_id  in  1 each  ID instruction reads rs / rt
- tuse0_id  in  1  ID instruction needs its operands in ID (branch, jr/jalr)
- id_is_md  in  1  ID instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- wa_ex  in  5  EX destination register (0 = no write)
- ex_is_load  in  1  EX instruction is a load
- wa_mem  in  5  MEM destination register (0 = no write)
- mem_is_load  in  1  MEM instruction is a load
- ex_md_start  in  1  EX issues mult/div this cycle
- ex_md_is_div  in  1  qualifies ex_md_start: 1 = div, 0 = mult
- if_id_stall  out  1  1 = IF/ID holds; drives IF_ID_we (the hold-on-high write enable)
- pc_stall  out  1  1 = PC holds; identical to if_id_stall
- id_ex_flush  out  1  1 = ID/EX loads a NOP at the next edge
- md_busy  out  1  mult/div unit occupied
- md_cnt  out  4  remaining busy cycles
- stall_count  out  32  total cycles with if_id_stall = 1

## Operation
- Register 0 never matches. A source matches only if its use_* bit is set and it equals a nonzero wa_*.
- **Load-use hazard:** a source matches wa_ex while ex_is_load = 1.
- **Tuse0 hazard:** tuse0_id = 1 and either:
  - a source matches wa_ex (any writer), or
  - a source matches wa_mem while mem_is_load = 1.
- **MD hazard:** id_is_md = 1 and md_busy = 1.
- stall = load-use | tuse0 | md.
- if_id_stall = pc_stall = id_ex_flush = stall.
  - Combinational from current inputs and state; no registered latency.
- md_busy = (md_cnt != 0) | ex_md_start.
- **Counter, at each rising edge:**
  - ex_md_start = 1: md_cnt loads DIV_CYCLES or MULT_CYCLES according to ex_md_is_div.
  - Else if md_cnt != 0: md_cnt decrements by 1.
  - Else: md_cnt holds 0.
  - ex_md_start while md_cnt != 0 reloads (restart). This takes priority over the decrement.
- stall_count increments by 1 on each edge where stall = 1. It saturates at 0xFFFFFFFF and does not wrap.

## Timing
- **Reset values:** md_cnt = 0 and stall_count = 0, applied immediately on reset assertion (asynchronous, not at the next edge).
- **Outputs while reset = 1:**
  - if_id_stall, pc_stall, id_ex_flush and md_busy are forced to 0.
  - The counters hold 0.
- **Reset mid-operation:** a pending mult/div count is discarded. After release, md_busy follows ex_md_start only.
- **Mult started in cycle t:**
  - md_busy is 1 in cycles t through t+5 (md_cnt = 5, 4, 3, 2, 1 in t+1 through t+5).
  - md_busy is 0 from t+6.
  - Div is the same with 10: busy in t through t+10.
- An ID md instruction stalls during those cycles and advances in the first cycle md_busy = 0.
- **Load-use:** exactly one stall cycle. At the next edge the load moves to MEM and the ID/EX bubble enters EX, so the hazard clears.
- **Tuse0 after an ALU writer in EX:** one stall cycle.
- **Tuse0 after a load in EX:** two stall cycles (load-use, then the MEM-load term).
- **Simultaneous hazards:** stall is the OR of all terms; no priority. stall_count increments once per cycle regardless of how many terms are active.

## Test plan
- Reset asserted mid-div (md_cnt = 7), with id_is_md = 1 -> md_cnt and stall_count read 0 immediately and all stall outputs are 0 during reset. After release with no start, md_busy = 0.
- Load lw into $8 in EX, with ID add reading rs = 8 (use_rs_id = 1) -> one cycle of if_id_stall = id_ex_flush = 1, then 0. Repeat with rs = 0 and wa_ex = 0 -> no stall.
- beq (tuse0_id = 1) with rt = 9; cycle 1: wa_ex = 9, ex_is_load = 1; cycle 2: wa_mem = 9, mem_is_load = 1 -> stall in both cycles, stall_count = 2.
- ex_md_start with ex_md_is_div = 0, then mflo held in ID -> md_busy high for 6 cycles with md_cnt sequence 5, 4, 3, 2, 1, 0; stall for 6 cycles; stall_count = 6.
- Div started, then ex_md_start with ex_md_is_div = 0 forced at md_cnt = 4 -> md_cnt reloads to 5 at the next edge.
- stall_count forced near 0xFFFFFFFE with stall held high for 3 cycles -> stall_count reads 0xFFFFFFFF and stays there.
